pwm_peripheral: RTL and testbench

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

---
 rtl/pwm_peripheral.sv | 114 +++++++++++
 tb/tb_pwm_peripheral.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel PWM output block driven by one shared counter.
//
// A prescaler divides clk by PRESCALE to produce counter steps. An 8-bit
// counter advances once per step, so one PWM period is PRESCALE*256 clks.
// Every channel compares against the same counter, which keeps their edges
// phase-aligned. Each channel is either off, constant high, or PWM.
//
// Optional build macro: PWM_DUTY_SHADOW_EN
//   defined   - the duty value is captured into a shadow register on the
//               counter wrap, so duty changes only land on period boundaries.
//   undefined - the duty input feeds the comparator directly and a change
//               is seen on the next clk.

module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_tick
);

    // PRESCALE == 1 still needs a one-bit counter that simply stays at zero.
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       pwm_cnt;
    logic             step;
    logic             wrap;
    logic [7:0]       duty_eff;
    logic             pwm_level;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;
    logic [15:0]      out_next;

    assign step = (pre_cnt == PRE_LAST);
    assign wrap = step && (pwm_cnt == 8'hFF);

    // Prescaler: counts 0..PRESCALE-1, the terminal count is the step cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (step) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Shared PWM counter: advances on steps only, wrapping naturally at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'h00;
        end else if (step) begin
            pwm_cnt <= pwm_cnt + 8'h01;
        end
    end

    // Period marker: registered copy of the wrap, so it is high while the counter reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_tick <= 1'b0;
        end else begin
            period_tick <= wrap;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_shadow;

    // Duty shadow: captured on the wrap edge so a period never mixes two duty values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= 8'h00;
        end else if (wrap) begin
            duty_shadow <= pwm_duty_cycle;
        end
    end

    assign duty_eff = duty_shadow;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // 8'hFF is treated as fully on so the output never dips low at the wrap.
    assign pwm_level = (duty_eff == 8'hFF) || (pwm_cnt < duty_eff);

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Channel select: off when disabled, constant high when not in PWM mode, else the PWM level.
    always_comb begin
        out_next = '0;
        for (int i = 0; i < 16; i++) begin
            out_next[i] = en_out[i] && (!en_pwm[i] || pwm_level);
        end
    end

    // Output register: every enable or level change shows up one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 16'h0000;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: self-checking bench for pwm_peripheral.
// Table vectors for static channel modes, period measurements for duty ratios,
// hand sequences for mid-period duty change and mid-period reset, and a
// randomized phase compared cycle by cycle against an arithmetic reference model.
// Honours PWM_DUTY_SHADOW_EN the same way the design does.

module tb_pwm_peripheral;

    localparam int P      = 13;
    localparam int PERIOD = 256 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out_v = '0;
    logic [15:0] en_pwm_v = '0;
    logic [7:0]  duty = '0;
    logic [15:0] out;
    logic        period_tick;

    int checks = 0;
    int failures = 0;
    int hi[16];

    typedef struct {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  d;
        logic [15:0] exp_o;
    } vec_t;

    vec_t vecs[9];

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out_v[7:0]),
        .en_reg_out_15_8 (en_out_v[15:8]),
        .en_reg_pwm_7_0  (en_pwm_v[7:0]),
        .en_reg_pwm_15_8 (en_pwm_v[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_tick     (period_tick)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference model: after k clks out of reset the counter reads floor(k/P) mod 256.
    int unsigned m_k = 0;
    logic [15:0] exp_out = '0;
    logic        exp_tick = 1'b0;
    logic [7:0]  m_d;

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] m_shadow = '0;
    assign m_d = m_shadow;
`else
    assign m_d = duty;
`endif

    function automatic logic [15:0] model_out(int unsigned k, logic [7:0] d,
                                              logic [15:0] eo, logic [15:0] ep);
        int unsigned cnt;
        logic        lvl;
        logic [15:0] r;
        cnt = (k / P) % 256;
        lvl = (d == 8'hFF) || (cnt < 32'(d));
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (eo[i]) r[i] = ep[i] ? lvl : 1'b1;
        end
        return r;
    endfunction

    function automatic int exp_high(logic eo, logic ep, logic [7:0] d);
        if (!eo) return 0;
        if (!ep || d == 8'hFF) return PERIOD;
        return int'(d) * P;
    endfunction

    // Model state advances on each rising edge, cleared whenever reset is low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k      <= 0;
            exp_out  <= '0;
            exp_tick <= 1'b0;
`ifdef PWM_DUTY_SHADOW_EN
            m_shadow <= '0;
`endif
        end else begin
            exp_out  <= model_out(m_k, m_d, en_out_v, en_pwm_v);
            m_k      <= m_k + 1;
            exp_tick <= ((m_k + 1) % PERIOD) == 0;
`ifdef PWM_DUTY_SHADOW_EN
            if (((m_k + 1) % PERIOD) == 0) m_shadow <= duty;
`endif
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_out_v = eo;
        en_pwm_v = ep;
        duty     = d;
    endtask

    task automatic step_cycles(input int n, input bit sb);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (sb) checkOutput("scoreboard {out,tick}", {15'b0, out, period_tick}, {15'b0, exp_out, exp_tick});
        end
    endtask

    task automatic wait_tick();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!period_tick && c < PERIOD + 4);
        checkOutput("tick_seen", {31'b0, period_tick}, 32'd1);
    endtask

    task automatic measure_period();
        int early;
        early = 0;
        for (int i = 0; i < 16; i++) hi[i] = 0;
        for (int j = 1; j <= PERIOD; j++) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) hi[i] += int'(out[i]);
            if (j < PERIOD && period_tick) early++;
        end
        checkOutput("tick_early", early, 0);
        checkOutput("tick_at_period_end", {31'b0, period_tick}, 32'd1);
    endtask

    task automatic measure_with(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        applyStimulus(eo, ep, d);
`ifdef PWM_DUTY_SHADOW_EN
        wait_tick();
`else
        if (!period_tick) wait_tick();
`endif
        measure_period();
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("high_clks d=%0h ch%0d", d, i), hi[i], exp_high(eo[i], ep[i], d));
        end
    endtask

    initial begin
        logic [7:0] last_d;
        int c;

        vecs[0] = '{16'hFFFF, 16'h0000, 8'h00, 16'hFFFF};
        vecs[1] = '{16'h0000, 16'h0000, 8'h00, 16'h0000};
        vecs[2] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
        vecs[5] = '{16'h00FF, 16'h000F, 8'hFF, 16'h00FF};
        vecs[6] = '{16'h00FF, 16'h000F, 8'h00, 16'h00F0};
        vecs[7] = '{16'hA5A5, 16'h0F0F, 8'h00, 16'hA0A0};
        vecs[8] = '{16'h3C3C, 16'hFF00, 8'hFF, 16'h3C3C};

        $display("[TB] reset state");
        applyStimulus(16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out", {16'b0, out}, 32'h0);
        checkOutput("reset_tick", {31'b0, period_tick}, 32'h0);
        rst_n = 1'b1;
        step_cycles(2, 1'b1);

        $display("[TB] table vectors");
        last_d = 8'h00;
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].eo, vecs[v].ep, vecs[v].d);
`ifdef PWM_DUTY_SHADOW_EN
            if (vecs[v].d != last_d) wait_tick();
`endif
            last_d = vecs[v].d;
            step_cycles(1, 1'b1);
            checkOutput($sformatf("vec%0d out", v), {16'b0, out}, {16'b0, vecs[v].exp_o});
        end

        $display("[TB] randomized phase");
        for (int r = 0; r < 75; r++) begin
            logic [7:0] d;
            case ($urandom_range(0, 7))
                0:       d = 8'h00;
                1:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            applyStimulus(16'($urandom), 16'($urandom), d);
            step_cycles(40, 1'b1);
        end

        $display("[TB] period measurements");
        measure_with(16'hFFFF, 16'hFFFF, 8'h80);
        measure_with(16'hFFFF, 16'hFFFF, 8'h40);
        measure_with(16'hFFFF, 16'hFFFF, 8'h00);
        measure_with(16'hFFFF, 16'hFFFF, 8'hFF);
        measure_with(16'h00FF, 16'h000F, 8'h80);

        $display("[TB] duty change mid-period");
        applyStimulus(16'hFFFF, 16'hFFFF, 8'h40);
`ifdef PWM_DUTY_SHADOW_EN
        wait_tick();
        for (int i = 0; i < 16; i++) hi[i] = 0;
        for (int j = 1; j <= PERIOD; j++) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) hi[i] += int'(out[i]);
            if (j == 1300) duty = 8'hC0;
        end
        checkOutput("change_period_tick", {31'b0, period_tick}, 32'd1);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("change_period ch%0d", i), hi[i], 832);
        measure_period();
        for (int i = 0; i < 16; i++) checkOutput($sformatf("after_change ch%0d", i), hi[i], 2496);
`else
        if (!period_tick) wait_tick();
        step_cycles(1300, 1'b0);
        checkOutput("pre_change_low", {16'b0, out}, 32'h0);
        duty = 8'hC0;
        step_cycles(2, 1'b0);
        checkOutput("change_within_2clk", {16'b0, out}, 32'hFFFF);
`endif

        $display("[TB] reset mid high phase");
        applyStimulus(16'hFFFF, 16'hFFFF, 8'h80);
        wait_tick();
        step_cycles(500, 1'b1);
        checkOutput("high_before_reset", {16'b0, out}, 32'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", {16'b0, out}, 32'h0);
        checkOutput("async_reset_tick", {31'b0, period_tick}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        do begin
            step_cycles(1, 1'b1);
            c++;
        end while (!period_tick && c < PERIOD + 4);
        checkOutput("first_tick_after_reset", c, PERIOD);
        step_cycles(20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
